io_handshake_ctrl: RTL and testbench

Sequencer for the processor's `in` and `out` instructions. It generates `flag_Halt` for the control unit, which freezes the PC while an I/O instruction waits for the operator. It debounces the Enter push-button and captures the switch value for `in`. It latches the register value shown by `out`. It sits between the control-unit outputs (`MuxIn_SelectIn`, `Out`), the register bank read port, the board switches/button and the display driver.

---
 rtl/io_handshake_ctrl.sv | 122 ++++++++++++
 tb/tb_io_handshake_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_handshake_ctrl.sv
// rtl/io_handshake_ctrl.sv - in/out instruction sequencer: Enter debounce, switch capture, display latch, PC halt
module io_handshake_ctrl #(
  parameter int DATA_W       = 32,
  parameter int SW_W         = 16,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              SelectIn,
  input  logic              Out,
  input  logic [DATA_W-1:0] RegValue,
  input  logic [SW_W-1:0]   Switches,
  input  logic              Enter,
  output logic              flag_Halt,
  output logic [DATA_W-1:0] InData,
  output logic [DATA_W-1:0] OutData,
  output logic              OutValid
);

  localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } state_t;

  state_t           state, state_next;
  logic             enter_m, enter_s, enter_db;
  logic [CNT_W-1:0] db_cnt;
  logic             db_flip, press_evt, release_evt;
  logic             req, load_in, load_out;

  // The edge events fire in the cycle whose closing edge flips enter_db,
  // so the FSM advances on the same edge the debounced level changes.
  assign db_flip     = (enter_s != enter_db) && (db_cnt == CNT_LAST);
  assign press_evt   = db_flip & enter_s;
  assign release_evt = db_flip & ~enter_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enter_m  <= 1'b0;
      enter_s  <= 1'b0;
      enter_db <= 1'b0;
      db_cnt   <= '0;
    end else begin
      enter_m <= Enter;
      enter_s <= enter_m;
      if (enter_s == enter_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        enter_db <= enter_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  assign req = SelectIn | Out;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // SelectIn wins when both requests are present, so Out only loads alone.
  always_comb begin
    state_next = state;
    load_in    = 1'b0;
    load_out   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = WAIT_PRESS;
          load_out   = ~SelectIn;
        end
      end
      WAIT_PRESS: begin
        if (!req) begin
          state_next = IDLE;
        end else if (press_evt) begin
          state_next = WAIT_RELEASE;
          load_in    = SelectIn;
        end
      end
      WAIT_RELEASE: begin
        if (!req) begin
          state_next = IDLE;
        end else if (release_evt) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      InData   <= '0;
      OutData  <= '0;
      OutValid <= 1'b0;
    end else begin
      if (load_in) begin
        InData <= DATA_W'(Switches);
      end
      if (load_out) begin
        OutData  <= RegValue;
        OutValid <= 1'b1;
      end
    end
  end

  assign flag_Halt = req & (state != DONE);

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// tb/tb_io_handshake_ctrl.sv - randomized self-checking bench for io_handshake_ctrl
module tb_io_handshake_ctrl;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;
  localparam int D      = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              SelectIn = 1'b0;
  logic              Out = 1'b0;
  logic              Enter = 1'b0;
  logic [DATA_W-1:0] RegValue = '0;
  logic [SW_W-1:0]   Switches = '0;
  logic              flag_Halt;
  logic [DATA_W-1:0] InData;
  logic [DATA_W-1:0] OutData;
  logic              OutValid;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural results of each completed or aborted I/O op.
  logic [DATA_W-1:0] m_in  = '0;
  logic [DATA_W-1:0] m_out = '0;
  logic              m_valid = 1'b0;

  io_handshake_ctrl #(
    .DATA_W(DATA_W),
    .SW_W(SW_W),
    .DEBOUNCE_CYC(D)
  ) dut (
    .clock(clock),
    .reset(reset),
    .SelectIn(SelectIn),
    .Out(Out),
    .RegValue(RegValue),
    .Switches(Switches),
    .Enter(Enter),
    .flag_Halt(flag_Halt),
    .InData(InData),
    .OutData(OutData),
    .OutValid(OutValid)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic hold_enter(input logic lvl, input int n, input string tag);
    Enter = lvl;
    for (int k = 0; k < n; k++) begin
      settle();
      check(tag, 32'(flag_Halt), 32'd1);
      step();
    end
  endtask

  // kind: 0 = in, 1 = out, 2 = both asserted (behaves as in)
  task automatic run_op(input int kind, input logic [15:0] sw, input logic [31:0] rv,
                        input bit held, input bit abort_op, input int nb, input int bseed,
                        input int p);
    logic si, so;
    int   halt_cnt;
    bit   done;
    si = (kind != 1);
    so = (kind != 0);
    if (held) begin
      Enter = 1'b1;
      Switches = ~sw;
      repeat (D + 4) step();
    end else begin
      Switches = sw;
    end
    SelectIn = si;
    Out = so;
    RegValue = rv;
    settle();
    check("halt_first", 32'(flag_Halt), 32'd1);
    step();
    if (so && !si) begin
      m_out = rv;
      m_valid = 1'b1;
    end
    check("out_data_early", OutData, m_out);
    check("out_valid_early", 32'(OutValid), 32'(m_valid));
    check("in_hold", InData, m_in);
    RegValue = $urandom;
    if (held) begin
      hold_enter(1'b1, 3, "halt_held");
      hold_enter(1'b0, D + 4, "halt_held_rel");
      Switches = sw;
      check("in_no_capture", InData, m_in);
    end
    for (int i = 0; i < nb; i++) begin
      hold_enter(1'b1, ((i + bseed) % (D - 1)) + 1, "halt_bounce");
      hold_enter(1'b0, 2 + (i % 3), "halt_bounce");
    end
    check("bounce_in_hold", InData, m_in);
    if (abort_op) begin
      SelectIn = 1'b0;
      Out = 1'b0;
      settle();
      check("abort_halt", 32'(flag_Halt), 32'd0);
      step();
      check("abort_in", InData, m_in);
      check("abort_out", OutData, m_out);
      return;
    end
    Enter = 1'b1;
    halt_cnt = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc == p) Enter = 1'b0;
      settle();
      if (!flag_Halt) begin
        done = 1'b1;
        break;
      end
      halt_cnt++;
      step();
    end
    Enter = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    if (si) m_in = {16'h0000, sw};
    check("halt_len", 32'(halt_cnt), 32'(p + 2 + D));
    check("in_data", InData, m_in);
    check("out_data", OutData, m_out);
    check("out_valid", 32'(OutValid), 32'(m_valid));
    SelectIn = 1'b0;
    Out = 1'b0;
    step();
    SelectIn = si;
    Out = so;
    settle();
    check("done_once", 32'(flag_Halt), 32'd1);
    SelectIn = 1'b0;
    Out = 1'b0;
    settle();
  endtask

  task automatic reset_mid_release();
    SelectIn = 1'b1;
    Switches = 16'h0F0F;
    step();
    Enter = 1'b1;
    repeat (D + 5) step();
    settle();
    check("pre_reset_halt", 32'(flag_Halt), 32'd1);
    reset = 1'b0;
    settle();
    m_in = '0;
    m_out = '0;
    m_valid = 1'b0;
    check("rst_out_data", OutData, 32'd0);
    check("rst_out_valid", 32'(OutValid), 32'd0);
    check("rst_in_data", InData, 32'd0);
    check("rst_halt_req", 32'(flag_Halt), 32'd1);
    Enter = 1'b0;
    SelectIn = 1'b0;
    step();
    step();
    reset = 1'b1;
    repeat (D + 4) step();
  endtask

  initial begin
    step();
    step();
    check("init_in", InData, 32'd0);
    check("init_out", OutData, 32'd0);
    check("init_valid", 32'(OutValid), 32'd0);
    check("init_halt_idle", 32'(flag_Halt), 32'd0);
    Out = 1'b1;
    settle();
    check("init_halt_req", 32'(flag_Halt), 32'd1);
    Out = 1'b0;
    reset = 1'b1;
    repeat (3) step();

    run_op(0, 16'hA5C3, 32'h0, 1'b0, 1'b0, 0, 0, 10);
    check("in_a5c3", InData, 32'h0000A5C3);
    run_op(1, 16'h0, 32'hDEADBEEF, 1'b0, 1'b0, 0, 0, D);
    check("out_deadbeef", OutData, 32'hDEADBEEF);
    run_op(0, 16'h3C3C, 32'h0, 1'b0, 1'b0, 3, 0, 6);
    run_op(0, 16'h1234, 32'h0, 1'b1, 1'b0, 0, 0, 5);
    run_op(2, 16'hBEEF, 32'h12345678, 1'b0, 1'b0, 1, 1, 7);
    check("both_out_kept", OutData, 32'hDEADBEEF);
    run_op(0, 16'h5555, 32'h0, 1'b0, 1'b1, 2, 0, 5);
    run_op(1, 16'h0, 32'hCAFEF00D, 1'b0, 1'b0, 0, 0, 4);
    run_op(1, 16'h0, 32'h0BADF00D, 1'b0, 1'b1, 1, 2, 4);

    reset_mid_release();

    for (int n = 0; n < 24; n++) begin
      run_op(int'($urandom_range(0, 2)), 16'($urandom), $urandom,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             D + int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
